// File: rtl/iir_pwm_feeder.sv
// Direct-form-I biquad computed with one shared multiplier (5 MAC cycles per sample),
// followed by offset-binary conversion and an end-of-cycle-gated handoff to the PWM.
module iir_pwm_feeder #(
    parameter int W     = 16,
    parameter int CW    = 16,
    parameter int FRAC  = 14,
    parameter int OUT_W = 31
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [W-1:0]  x_in,
    input  logic                 x_valid,
    input  logic signed [CW-1:0] b0,
    input  logic signed [CW-1:0] b1,
    input  logic signed [CW-1:0] b2,
    input  logic signed [CW-1:0] a1,
    input  logic signed [CW-1:0] a2,
    input  logic                 pwm_eoc,
    output logic signed [W-1:0]  y_out,
    output logic                 y_valid,
    output logic                 busy,
    output logic                 overrun,
    output logic [OUT_W-1:0]     pwm_code
);
    localparam int AW = W + CW + 3;
    localparam int PW = W + CW;

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t                state_q, state_d;
    logic [2:0]            k_q, k_d;
    logic signed [AW-1:0]  acc_q, acc_d;
    logic signed [W-1:0]   x0_q, x1_q, x2_q, y1_q, y2_q;
    logic signed [W-1:0]   y_out_q;
    logic                  y_valid_q, busy_q, overrun_q;
    logic [OUT_W-1:0]      pending_q, pwm_code_q;
    logic                  pending_valid_q;
    logic                  accept;

    logic signed [CW-1:0]  op_c;
    logic signed [W-1:0]   op_x;
    logic                  op_neg;
    logic signed [PW-1:0]  prod;
    logic signed [AW-1:0]  prod_ext;
    logic signed [AW-1:0]  shifted;
    logic [AW-W:0]         top_bits;
    logic signed [W-1:0]   y_sat;
    logic [OUT_W-1:0]      code_new;

    // Operand select: tap k of the biquad; feedback taps are subtracted.
    always_comb begin
        op_c   = b0;
        op_x   = x0_q;
        op_neg = 1'b0;
        case (k_q)
            3'd0:    begin op_c = b0; op_x = x0_q; end
            3'd1:    begin op_c = b1; op_x = x1_q; end
            3'd2:    begin op_c = b2; op_x = x2_q; end
            3'd3:    begin op_c = a1; op_x = y1_q; op_neg = 1'b1; end
            default: begin op_c = a2; op_x = y2_q; op_neg = 1'b1; end
        endcase
    end

    assign prod     = PW'(op_c) * PW'(op_x);
    assign prod_ext = {{(AW-PW){prod[PW-1]}}, prod};

    // Result is in range only if every bit above the W-bit sign agrees with it.
    assign shifted  = acc_q >>> FRAC;
    assign top_bits = shifted[AW-1:W-1];

    always_comb begin
        if (top_bits == '0 || top_bits == '1)
            y_sat = shifted[W-1:0];
        else if (shifted[AW-1])
            y_sat = {1'b1, {(W-1){1'b0}}};
        else
            y_sat = {1'b0, {(W-1){1'b1}}};
    end

    assign code_new = OUT_W'({~y_sat[W-1], y_sat[W-2:0]}) << (OUT_W - W);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        acc_d   = acc_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (x_valid) begin
                    accept  = 1'b1;
                    acc_d   = '0;
                    k_d     = 3'd0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = op_neg ? acc_q - prod_ext : acc_q + prod_ext;
                k_d   = k_q + 3'd1;
                if (k_q == 3'd4)
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            k_q             <= '0;
            acc_q           <= '0;
            x0_q            <= '0;
            x1_q            <= '0;
            x2_q            <= '0;
            y1_q            <= '0;
            y2_q            <= '0;
            y_out_q         <= '0;
            y_valid_q       <= 1'b0;
            busy_q          <= 1'b0;
            overrun_q       <= 1'b0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            pwm_code_q      <= OUT_W'(1) << (OUT_W - 1);
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            acc_q     <= acc_d;
            busy_q    <= (state_d != IDLE);
            y_valid_q <= (state_q == DONE);
            if (accept)
                x0_q <= x_in;
            if (x_valid && busy_q)
                overrun_q <= 1'b1;
            if (state_q == DONE) begin
                y_out_q   <= y_sat;
                x2_q      <= x1_q;
                x1_q      <= x0_q;
                y2_q      <= y1_q;
                y1_q      <= y_sat;
                pending_q <= code_new;
                // A fresh result coinciding with end-of-cycle bypasses the pending slot.
                if (pwm_eoc) begin
                    pwm_code_q      <= code_new;
                    pending_valid_q <= 1'b0;
                end else begin
                    pending_valid_q <= 1'b1;
                end
            end else if (pwm_eoc && pending_valid_q) begin
                pwm_code_q      <= pending_q;
                pending_valid_q <= 1'b0;
            end
        end
    end

    assign y_out    = y_out_q;
    assign y_valid  = y_valid_q;
    assign busy     = busy_q;
    assign overrun  = overrun_q;
    assign pwm_code = pwm_code_q;

endmodule

// File: tb/tb_iir_pwm_feeder.sv
// Randomized and directed bench for iir_pwm_feeder against an arithmetic biquad/handoff model.
module tb_iir_pwm_feeder;
    localparam int W = 16, CW = 16, FRAC = 14, OUT_W = 31;
    localparam logic [OUT_W-1:0] MID = 31'h40000000;

    logic                 clk = 1'b0;
    logic                 rst;
    logic signed [W-1:0]  x_in;
    logic                 x_valid;
    logic signed [CW-1:0] b0, b1, b2, a1, a2;
    logic                 pwm_eoc;
    logic signed [W-1:0]  y_out;
    logic                 y_valid, busy, overrun;
    logic [OUT_W-1:0]     pwm_code;

    iir_pwm_feeder #(.W(W), .CW(CW), .FRAC(FRAC), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst(rst), .x_in(x_in), .x_valid(x_valid),
        .b0(b0), .b1(b1), .b2(b2), .a1(a1), .a2(a2), .pwm_eoc(pwm_eoc),
        .y_out(y_out), .y_valid(y_valid), .busy(busy), .overrun(overrun),
        .pwm_code(pwm_code)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // model state: filter history and PWM handoff
    int               mx1, mx2, my1, my2;
    logic [OUT_W-1:0] m_code, m_pend;
    bit               m_pv;

    task automatic model_step(input int x, output int y);
        longint s, q;
        s = longint'(b0) * x + longint'(b1) * mx1 + longint'(b2) * mx2
          - longint'(a1) * my1 - longint'(a2) * my2;
        q = s / 16384;
        if (s < 0 && q * 16384 != s) q = q - 1;
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
        y = int'(q);
        mx2 = mx1; mx1 = x; my2 = my1; my1 = y;
    endtask

    function automatic logic [OUT_W-1:0] code_of(input int y);
        longint c;
        c = (longint'(y) + 32768) * 32768;
        return c[OUT_W-1:0];
    endfunction

    task automatic model_done(input int y, input bit eoc);
        if (eoc) begin m_code = code_of(y); m_pv = 0; end
        else     begin m_pend = code_of(y); m_pv = 1; end
    endtask

    task automatic do_reset(input int c0, input int c1, input int c2, input int c3, input int c4);
        b0 = 16'(c0); b1 = 16'(c1); b2 = 16'(c2); a1 = 16'(c3); a2 = 16'(c4);
        rst = 1; x_valid = 0; pwm_eoc = 0; x_in = '0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
        m_code = MID; m_pend = '0; m_pv = 0;
    endtask

    task automatic pulse_eoc();
        pwm_eoc = 1;
        @(posedge clk); #1;
        pwm_eoc = 0;
        if (m_pv) begin m_code = m_pend; m_pv = 0; end
    endtask

    // Drives one sample and waits (bounded) for y_valid; lat = edges after acceptance, -1 on timeout.
    task automatic run_sample(input int x, input bit eoc_at_done, output int y, output int lat);
        x_in = 16'(x); x_valid = 1;
        @(posedge clk); #1;
        x_valid = 0; lat = -1; y = 0;
        for (int n = 1; n <= 20; n++) begin
            if (eoc_at_done && n == 6) pwm_eoc = 1;
            @(posedge clk); #1;
            pwm_eoc = 0;
            if (y_valid) begin lat = n; y = int'(y_out); break; end
        end
    endtask

    task automatic test_reset();
        do_reset(0, 0, 0, 0, 0);
        n_tests++; if (pwm_code !== MID) begin n_fail++; $display("FAIL reset_pwm: got %h want %h", pwm_code, MID); end
        n_tests++; if (y_out !== 16'sd0) begin n_fail++; $display("FAIL reset_y: got %0d want 0", y_out); end
        n_tests++; if ({busy, overrun, y_valid} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {busy, overrun, y_valid}); end
        repeat (3) begin pulse_eoc(); @(posedge clk); #1; end
        n_tests++; if (pwm_code !== MID) begin n_fail++; $display("FAIL idle_eoc_pwm: got %h want %h", pwm_code, MID); end
    endtask

    task automatic test_passthrough();
        int y, ye, lat;
        do_reset(16384, 0, 0, 0, 0);
        run_sample(1000, 0, y, lat);
        model_step(1000, ye); model_done(ye, 0);
        n_tests++; if (lat !== 6) begin n_fail++; $display("FAIL pass_latency: got %0d want 6", lat); end
        n_tests++; if (y !== ye) begin n_fail++; $display("FAIL pass_y: got %0d want %0d", y, ye); end
        @(posedge clk); #1;
        n_tests++; if (y_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL pass_one_pulse: got vld=%b busy=%b want 0 0", y_valid, busy); end
        n_tests++; if (pwm_code !== MID) begin n_fail++; $display("FAIL pass_hold: got %h want %h", pwm_code, MID); end
        pulse_eoc();
        n_tests++; if (pwm_code !== m_code) begin n_fail++; $display("FAIL pass_pwm: got %h want %h", pwm_code, m_code); end
    endtask

    task automatic test_decay();
        int xs[4] = '{1000, 0, 0, 0};
        int y, ye, lat;
        do_reset(16384, 0, 0, -8192, 0);
        foreach (xs[i]) begin
            run_sample(xs[i], 0, y, lat);
            model_step(xs[i], ye);
            n_tests++; if (y !== ye || lat !== 6) begin n_fail++; $display("FAIL decay_%0d: got %0d (lat %0d) want %0d", i, y, lat, ye); end
        end
        do_reset(8192, 0, 0, 0, 0);
        run_sample(-1, 0, y, lat);
        model_step(-1, ye);
        n_tests++; if (y !== ye) begin n_fail++; $display("FAIL floor_neg: got %0d want %0d", y, ye); end
    endtask

    task automatic test_saturation();
        int y, ye, lat;
        for (int s = 0; s < 2; s++) begin
            int x;
            x = (s == 0) ? 30000 : -30000;
            do_reset(16384, 16384, 0, 0, 0);
            for (int i = 0; i < 2; i++) begin
                run_sample(x, 0, y, lat);
                model_step(x, ye);
                n_tests++; if (y !== ye) begin n_fail++; $display("FAIL sat_%0d_%0d: got %0d want %0d", s, i, y, ye); end
            end
        end
    endtask

    task automatic test_handoff();
        int y, ye, lat;
        bit moved;
        do_reset(16384, 0, 0, 0, 0);
        run_sample(1000, 0, y, lat); model_step(1000, ye); model_done(ye, 0);
        moved = 0;
        repeat (20) begin @(posedge clk); #1; if (pwm_code !== MID) moved = 1; end
        n_tests++; if (moved) begin n_fail++; $display("FAIL hold_no_eoc: got %h want %h", pwm_code, MID); end
        pulse_eoc();
        n_tests++; if (pwm_code !== m_code) begin n_fail++; $display("FAIL hold_then_eoc: got %h want %h", pwm_code, m_code); end
        run_sample(2000, 0, y, lat);  model_step(2000, ye);  model_done(ye, 0);
        run_sample(-3000, 0, y, lat); model_step(-3000, ye); model_done(ye, 0);
        pulse_eoc();
        n_tests++; if (pwm_code !== m_code) begin n_fail++; $display("FAIL latest_only: got %h want %h", pwm_code, m_code); end
        run_sample(4000, 1, y, lat); model_step(4000, ye); model_done(ye, 1);
        n_tests++; if (pwm_code !== m_code) begin n_fail++; $display("FAIL eoc_at_done: got %h want %h", pwm_code, m_code); end
        run_sample(-500, 0, y, lat); model_step(-500, ye); model_done(ye, 0);
        n_tests++; if (pwm_code !== m_code) begin n_fail++; $display("FAIL no_eoc_hold: got %h want %h", pwm_code, m_code); end
    endtask

    task automatic test_overrun();
        int y, ye, lat, cnt, ycap;
        do_reset(16384, 16384, 0, 0, 0);
        x_in = 16'sd1000; x_valid = 1;
        @(posedge clk); #1; x_valid = 0;
        repeat (2) @(posedge clk);
        #1 x_in = 16'sd7777; x_valid = 1;
        @(posedge clk); #1; x_valid = 0;
        cnt = 0; ycap = 0;
        repeat (15) begin @(posedge clk); #1; if (y_valid) begin cnt++; ycap = int'(y_out); end end
        model_step(1000, ye); model_done(ye, 0);
        n_tests++; if (cnt !== 1) begin n_fail++; $display("FAIL ovr_count: got %0d want 1", cnt); end
        n_tests++; if (ycap !== ye) begin n_fail++; $display("FAIL ovr_y: got %0d want %0d", ycap, ye); end
        n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b want 1", overrun); end
        run_sample(2000, 0, y, lat); model_step(2000, ye);
        n_tests++; if (y !== ye || overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_after: got %0d/%b want %0d/1", y, overrun, ye); end
    endtask

    task automatic test_reset_mid();
        int y, ye, lat, cnt;
        do_reset(16384, 16384, 0, 0, 0);
        run_sample(1000, 0, y, lat); model_step(1000, ye); model_done(ye, 0);
        pulse_eoc();
        x_in = 16'sd500; x_valid = 1;
        @(posedge clk); #1; x_valid = 0;
        @(posedge clk); #1; rst = 1;
        @(posedge clk); #1; rst = 0;
        mx1 = 0; mx2 = 0; my1 = 0; my2 = 0; m_code = MID; m_pv = 0;
        cnt = 0;
        repeat (10) begin @(posedge clk); #1; if (y_valid) cnt++; end
        n_tests++; if (cnt !== 0) begin n_fail++; $display("FAIL rstmid_novalid: got %0d want 0", cnt); end
        n_tests++; if (pwm_code !== MID || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_state: got %h/%b want %h/0", pwm_code, busy, MID); end
        run_sample(500, 0, y, lat); model_step(500, ye);
        n_tests++; if (y !== ye) begin n_fail++; $display("FAIL rstmid_history: got %0d want %0d", y, ye); end
    endtask

    task automatic test_random();
        int y, ye, lat, x;
        bit eoc_done;
        do_reset(int'(16'($urandom)), int'(16'($urandom)), int'(16'($urandom)),
                 int'(16'($urandom)), int'(16'($urandom)));
        for (int i = 0; i < 40; i++) begin
            x = int'($urandom_range(0, 65535)) - 32768;
            eoc_done = ($urandom_range(0, 3) == 0);
            run_sample(x, eoc_done, y, lat);
            model_step(x, ye); model_done(ye, eoc_done);
            n_tests++; if (y !== ye || lat !== 6) begin n_fail++; $display("FAIL rand_y_%0d: got %0d (lat %0d) want %0d", i, y, lat, ye); end
            if ($urandom_range(0, 1) == 1) pulse_eoc();
            n_tests++; if (pwm_code !== m_code) begin n_fail++; $display("FAIL rand_pwm_%0d: got %h want %h", i, pwm_code, m_code); end
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_decay();
        test_saturation();
        test_handoff();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/iir_pwm_feeder.md
Name: iir_pwm_feeder

Overview:
- Upstream stage of the PWM DAC in the mixed-signal IIR path.
- Computes one direct-form-I biquad output per input sample using a single shared multiplier (sequential MAC).
- Converts the result to an unsigned offset-binary PWM code.
- Hands that code to the PWM only at the PWM end-of-cycle strobe, so the duty cycle never changes mid-period.

Parameters:
- W, 16, signed sample width of x_in and y_out.
- CW, 16, signed coefficient width.
- FRAC, 14, fractional bits of the coefficients (Q1.14 by default; 16384 = 1.0).
- OUT_W, 31, width of pwm_code (must equal the PWM counter width, OUT_W >= W).

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- x_in  in  W  signed input sample.
- x_valid  in  1  one-cycle strobe: x_in is valid.
- b0, b1, b2  in  CW each  signed feed-forward coefficients (static during operation).
- a1, a2  in  CW each  signed feedback coefficients (static during operation).
- pwm_eoc  in  1  end-of-cycle strobe from the PWM.
- y_out  out  W  signed saturated filter output.
- y_valid  out  1  one-cycle strobe: y_out updated.
- busy  out  1  high while a sample is being computed.
- overrun  out  1  sticky flag: an x_valid arrived while busy.
- pwm_code  out  OUT_W  unsigned code driving the PWM digital_in.

Behaviour:
- Reset: rst is synchronous and active-high; clk is the only clock.
  - On reset, all of these clear to 0: x1, x2, y1, y2, accumulator, y_out, y_valid, busy, overrun, pending, pending_valid.
  - pwm_code resets to 2^(OUT_W-1), the mid-scale (zero-signal) duty.
  - FSM returns to IDLE.
  - Reset mid-computation abandons the sample; no y_valid is produced for it.
- Filter equation: y[n] = sat_W((b0*x[n] + b1*x[n-1] + b2*x[n-2] - a1*y[n-1] - a2*y[n-2]) >>> FRAC).
  - Accumulator is signed, W+CW+3 bits wide, so it never overflows internally.
  - The shift is arithmetic, truncating toward minus infinity.
  - sat_W clamps to [-2^(W-1), 2^(W-1)-1].
- FSM states: IDLE, MAC, DONE.
  - IDLE: on x_valid, latch x_in, clear the accumulator, set busy, go to MAC with k=0.
  - MAC: one product per cycle in order k=0..4 (b0*x, b1*x1, b2*x2, -a1*y1, -a2*y2). After k=4, go to DONE.
  - DONE: saturate the result and register y_out. Pulse y_valid on the registered output. Shift history (x2<=x1, x1<=x, y2<=y1, y1<=saturated y). Load pending. Clear busy. Return to IDLE.
- Latency: x_valid sampled at edge E0 gives y_out/y_valid valid after edge E0+6. Throughput is at most one sample per 7 cycles.
- y_valid is high for exactly one cycle per accepted sample.
- Overrun: x_valid while busy=1 (MAC or DONE) is dropped and sets overrun. overrun stays set until rst. x_valid in IDLE the cycle after DONE is accepted.
- PWM handoff:
  - pending <= (y + 2^(W-1)) << (OUT_W-W), unsigned; pending_valid is set.
  - When pwm_eoc=1 and pending_valid=1: pwm_code <= pending and pending_valid clears.
  - If DONE and pwm_eoc occur in the same cycle, the newly computed code goes straight to pwm_code.
  - A newer result overwrites an untransferred pending value; only the latest is kept.
  - pwm_code never changes in a cycle without pwm_eoc.

Test Plan:
- Reset/idle: assert rst 2 cycles -> pwm_code = 0x40000000, y_out = 0, busy = 0, overrun = 0. Toggle pwm_eoc without samples -> pwm_code unchanged.
- Pass-through: b0 = 16384, others 0, x_in = 1000 at E0 -> y_valid after E0+6 with y_out = 1000. On the next pwm_eoc, pwm_code = (1000+32768)<<15 = 0x41F40000.
- Feedback decay: b0 = 16384, a1 = -8192, others 0; inputs 1000, 0, 0, 0 -> y_out = 1000, 500, 250, 125. Input -1 with b0 = 8192 -> y_out = -1 (floor).
- Saturation: b0 = b1 = 16384; inputs 30000, 30000 -> y_out = 30000, then 32767. Inputs -30000, -30000 from a fresh reset -> y_out = -30000, then -32768.
- Handoff timing: result ready with pwm_eoc held low 20 cycles -> pwm_code unchanged until pwm_eoc. Two results before one eoc -> only the second is loaded. DONE coincident with eoc -> new code appears the next cycle.
- Overrun/reset: x_valid at E0 and again at E3 -> second sample dropped, overrun = 1, one y_valid only. rst at E2 -> no y_valid, history cleared, pwm_code back to mid-scale.
